// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Consumer side of the hazard interface for the 5-stage 16-bit pipeline.
// The block turns hazard requests into per-stage write enables, flushes and
// bubble inserts. It also handles halt draining and keeps saturating debug
// counters.
//
// Parameters
//   DRAIN_CYCLES : cycles spent in DRAIN after HLT is accepted (1..15)
//   CNT_W        : width of the stall/flush event counters
//
// Ports
//   clk          : core clock
//   rst          : synchronous, active-high reset
//   stall_req    : load-use hazard request (level)
//   hlt_req      : HLT opcode present in IF/ID
//   branch_taken : branch/jump resolved taken in ID this cycle
//   pc_wen       : PC register write enable
//   if_id_wen    : IF/ID register write enable
//   if_id_flush  : IF/ID loads a NOP on the next edge
//   id_ex_bubble : ID/EX loads a control-zero bubble on the next edge
//   halted       : core halted (level)
//   stall_count  : load-use bubbles inserted (saturating)
//   flush_count  : taken-branch flushes (saturating)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             hlt_req,
  input  logic             branch_taken,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  // The counter is loaded with DRAIN_CYCLES-1 on accept. DRAIN then lasts
  // DRAIN_CYCLES cycles, ending with the cycle that sees the counter at zero.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // NOTE: every signal written here is given a default first. A path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_wen       = 1'b0;
    if_id_wen    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    unique case (state_q)
      RUN, STALL: begin
        if (branch_taken) begin
          // The instruction in IF/ID is wrong-path, so its HLT or stall is
          // dropped. The branch itself proceeds into EX, so no bubble is
          // inserted.
          pc_wen      = 1'b1;
          if_id_wen   = 1'b1;
          if_id_flush = 1'b1;
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
          state_d     = RUN;
        end else if (hlt_req) begin
          id_ex_bubble = 1'b1;
          drain_d      = DRAIN_LOAD;
          state_d      = DRAIN;
        end else if (stall_req && (state_q == RUN)) begin
          // In STALL the load has already moved to MEM. The request still
          // shown that cycle is stale and is masked, so each load-use pair
          // gets exactly one bubble.
          id_ex_bubble = 1'b1;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
          state_d      = STALL;
        end else begin
          pc_wen    = 1'b1;
          if_id_wen = 1'b1;
          state_d   = RUN;
        end
      end

      DRAIN: begin
        id_ex_bubble = 1'b1;
        if (drain_q == 4'd0) state_d = HALTED;
        else                 drain_d = drain_q - 4'd1;
      end

      HALTED: begin
        id_ex_bubble = 1'b1;
      end

      default: state_d = RUN;
    endcase

    // While reset is held, the pipeline must not advance or insert anything.
    if (rst) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted      = (state_q == HALTED) && !rst;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Directed bench for pipeline_ctrl. The main instance uses default parameters.
// A second instance with CNT_W=4 covers counter saturation.
//
// Inputs change on the falling edge and outputs are sampled 1 ns later. This
// means combinational outputs reflect the current state plus the new inputs,
// and registered values reflect the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall_req, hlt_req, branch_taken;
  logic        pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted;
  logic [15:0] stall_count, flush_count;

  logic        s_rst, s_stall;
  logic        s_pc_wen, s_if_id_wen, s_if_id_flush, s_id_ex_bubble, s_halted;
  logic [3:0]  s_stall_count, s_flush_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .hlt_req      (hlt_req),
    .branch_taken (branch_taken),
    .pc_wen       (pc_wen),
    .if_id_wen    (if_id_wen),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .halted       (halted),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst          (s_rst),
    .stall_req    (s_stall),
    .hlt_req      (1'b0),
    .branch_taken (1'b0),
    .pc_wen       (s_pc_wen),
    .if_id_wen    (s_if_id_wen),
    .if_id_flush  (s_if_id_flush),
    .id_ex_bubble (s_id_ex_bubble),
    .halted       (s_halted),
    .stall_count  (s_stall_count),
    .flush_count  (s_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then let outputs settle.
  task automatic drive(input logic r, input logic b, input logic h, input logic s);
    @(negedge clk);
    rst = r; branch_taken = b; hlt_req = h; stall_req = s;
    #1;
  endtask

  // Enables/flush/bubble in one call.
  task automatic check_ctl(input string tag, input logic pc, input logic fl, input logic bub);
    check({tag, ".pc_wen"},       32'(pc_wen),       32'(pc));
    check({tag, ".if_id_wen"},    32'(if_id_wen),    32'(pc));
    check({tag, ".if_id_flush"},  32'(if_id_flush),  32'(fl));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; hlt_req = 1'b0; stall_req = 1'b0;
    s_rst = 1'b1; s_stall = 1'b0;

    // Reset for two cycles: every enable is held low.
    drive(1, 0, 0, 0); check_ctl("rst0", 0, 0, 0);
    drive(1, 0, 0, 0); check_ctl("rst1", 0, 0, 0);

    // Idle RUN for five cycles.
    drive(0, 0, 0, 0);
    check("rst.stall_count", 32'(stall_count), 32'd0);
    check("rst.flush_count", 32'(flush_count), 32'd0);
    check("rst.halted",      32'(halted),      32'd0);
    check_ctl("idle0", 1, 0, 0);
    for (int i = 1; i < 5; i++) begin
      drive(0, 0, 0, 0);
      check_ctl("idle", 1, 0, 0);
    end

    // stall_req held for three cycles: bubble, masked proceed, bubble.
    drive(0, 0, 0, 1); check_ctl("ld_use0", 0, 0, 1);
    drive(0, 0, 0, 1); check_ctl("ld_use1_masked", 1, 0, 0);
    drive(0, 0, 0, 1); check_ctl("ld_use2", 0, 0, 1);
    drive(0, 0, 0, 0); check_ctl("ld_use_after", 1, 0, 0);
    check("ld_use.stall_count", 32'(stall_count), 32'd2);

    // Branch, HLT and stall together: the branch wins.
    drive(0, 1, 1, 1); check_ctl("all_req", 1, 1, 0);
    drive(0, 0, 0, 0); check_ctl("all_req_after", 1, 0, 0);
    check("all_req.flush_count", 32'(flush_count), 32'd1);
    check("all_req.stall_count", 32'(stall_count), 32'd2);
    check("all_req.halted",      32'(halted),      32'd0);

    // A branch in STALL is honoured and the stale stall stays masked.
    drive(0, 0, 0, 1); check_ctl("stall_br0", 0, 0, 1);
    drive(0, 1, 0, 1); check_ctl("stall_br1", 1, 1, 0);
    check("stall_br.stall_count", 32'(stall_count), 32'd3);
    drive(0, 0, 0, 0); check_ctl("stall_br2", 1, 0, 0);
    check("stall_br.flush_count", 32'(flush_count), 32'd2);

    // HLT accept, then three DRAIN cycles that ignore requests, then HALTED.
    drive(0, 0, 1, 0); check_ctl("hlt_accept", 0, 0, 1);
    check("hlt_accept.halted", 32'(halted), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1); check_ctl("drain", 0, 0, 1);
      check("drain.halted", 32'(halted), 32'd0);
    end
    drive(0, 1, 0, 1); check_ctl("halted0", 0, 0, 1);
    check("halted0.halted", 32'(halted), 32'd1);
    drive(0, 1, 1, 1); check_ctl("halted1", 0, 0, 1);
    check("halted1.halted",      32'(halted),      32'd1);
    check("halted.stall_count",  32'(stall_count), 32'd3);
    check("halted.flush_count",  32'(flush_count), 32'd2);

    // Leave HALTED by reset, then take a branch so a counter is non-zero.
    drive(1, 0, 0, 0); check_ctl("rst_halt", 0, 0, 0);
    check("rst_halt.halted", 32'(halted), 32'd0);
    drive(0, 1, 0, 0); check_ctl("restart_br", 1, 1, 0);
    drive(0, 0, 0, 0);
    check("restart.flush_count", 32'(flush_count), 32'd1);

    // Reset in the second DRAIN cycle returns to RUN with cleared counters.
    drive(0, 0, 1, 0); check_ctl("hlt2_accept", 0, 0, 1);
    drive(0, 0, 0, 0); check_ctl("hlt2_drain1", 0, 0, 1);
    drive(1, 0, 0, 0); check_ctl("hlt2_drain2_rst", 0, 0, 0);
    drive(0, 0, 0, 0); check_ctl("post_rst", 1, 0, 0);
    check("post_rst.halted",      32'(halted),      32'd0);
    check("post_rst.flush_count", 32'(flush_count), 32'd0);
    check("post_rst.stall_count", 32'(stall_count), 32'd0);

    // Saturation with CNT_W=4: 20 request/idle pairs.
    @(negedge clk); s_rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); s_stall = 1'b1;
      @(negedge clk); s_stall = 1'b0;
      #1;
      if (i == 5)  check("sat.count5",  32'(s_stall_count), 32'd5);
      if (i == 15) check("sat.count15", 32'(s_stall_count), 32'd15);
    end
    check("sat.count20",  32'(s_stall_count), 32'd15);
    check("sat.flush",    32'(s_flush_count), 32'd0);
    check("sat.pc_wen",   32'(s_pc_wen),      32'd1);
    @(negedge clk); s_stall = 1'b1;
    @(negedge clk); s_stall = 1'b0;
    #1;
    check("sat.hold", 32'(s_stall_count), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
